// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 subset controller: fetch/decode/exec/mem/writeback sequencing.
// Define MC_MEM_TIMEOUT_EN to trap after 16 consecutive not-ready memory wait cycles.
//   state  | meaning
//   FETCH  | request instruction, latch IR and bump PC on imem_ready
//   DECODE | register instruction class and ALU op, trap if illegal
//   EXEC   | drive ALU, resolve BEQ
//   MEM    | hold load/store strobe until dmem_ready
//   WB     | register file write
//   TRAP   | absorbing fault state, left only by rst
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic        zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_write,
  output logic        pc_inc,
  output logic        reg_write,
  output logic        mem_write,
  output logic        mem_read,
  output logic        load_from_dm,
  output logic [2:0]  ALU_op,
  output logic        branch_taken,
  output logic        trap,
  output logic [2:0]  state,
  output logic [15:0] retire_cnt
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] TRAP   = 3'd5;

  localparam logic [2:0] CL_NONE = 3'd0;
  localparam logic [2:0] CL_ALU  = 3'd1;
  localparam logic [2:0] CL_LW   = 3'd2;
  localparam logic [2:0] CL_SW   = 3'd3;
  localparam logic [2:0] CL_BEQ  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [2:0]  class_q, class_d;
  logic [2:0]  alu_op_q, alu_op_d;
  logic [15:0] retire_cnt_q, retire_cnt_d;
  logic [2:0]  dec_class;
  logic [2:0]  dec_alu;
  logic        dec_legal;
  logic        wait_expired;

  always_comb begin
    dec_legal = 1'b0;
    dec_class = CL_NONE;
    dec_alu   = 3'b000;
    case (opcode)
      7'b0110011: begin
        if (funct7 == 7'b0000000) begin
          dec_legal = 1'b1;
          dec_class = CL_ALU;
          case (funct3)
            3'b000:  dec_alu = 3'b000;
            3'b001:  dec_alu = 3'b110;
            3'b010:  dec_alu = 3'b011;
            3'b011:  dec_alu = 3'b011;
            3'b100:  dec_alu = 3'b101;
            3'b101:  dec_alu = 3'b111;
            3'b110:  dec_alu = 3'b010;
            default: dec_alu = 3'b100;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_legal = 1'b1;
          dec_class = CL_ALU;
          dec_alu   = 3'b001;
        end
      end
      7'b0010011: begin
        dec_class = CL_ALU;
        case (funct3)
          3'b000:  begin dec_legal = 1'b1; dec_alu = 3'b000; end
          3'b110:  begin dec_legal = 1'b1; dec_alu = 3'b010; end
          3'b010:  begin dec_legal = 1'b1; dec_alu = 3'b011; end
          default: dec_legal = 1'b0;
        endcase
      end
      7'b0000011: begin dec_legal = 1'b1; dec_class = CL_LW; end
      7'b0100011: begin dec_legal = 1'b1; dec_class = CL_SW; end
      7'b1100011: begin
        dec_legal = (funct3 == 3'b000);
        dec_class = CL_BEQ;
        dec_alu   = 3'b001;
      end
      default: dec_legal = 1'b0;
    endcase
    if (!dec_legal) dec_class = CL_NONE;
  end

`ifdef MC_MEM_TIMEOUT_EN
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       waiting;

  always_comb begin
    waiting      = (state_q == FETCH && !imem_ready) || (state_q == MEM && !dmem_ready);
    wait_expired = waiting && (wait_cnt_q == 4'd15);
    // any exit from the wait (ready, timeout) restarts the count
    wait_cnt_d   = (waiting && !wait_expired) ? wait_cnt_q + 4'd1 : 4'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) wait_cnt_q <= 4'd0;
    else     wait_cnt_q <= wait_cnt_d;
  end
`else
  assign wait_expired = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    class_d      = class_q;
    alu_op_d     = alu_op_q;
    retire_cnt_d = retire_cnt_q;
    case (state_q)
      FETCH: begin
        if (imem_ready)        state_d = DECODE;
        else if (wait_expired) state_d = TRAP;
      end
      DECODE: begin
        class_d  = dec_class;
        alu_op_d = dec_alu;
        state_d  = dec_legal ? EXEC : TRAP;
      end
      EXEC: begin
        case (class_q)
          CL_ALU:        state_d = WB;
          CL_LW, CL_SW:  state_d = MEM;
          CL_BEQ: begin
            state_d      = FETCH;
            retire_cnt_d = retire_cnt_q + 16'd1;
          end
          default:       state_d = TRAP;
        endcase
      end
      MEM: begin
        if (dmem_ready) begin
          if (class_q == CL_LW) begin
            state_d = WB;
          end else begin
            state_d      = FETCH;
            retire_cnt_d = retire_cnt_q + 16'd1;
          end
        end else if (wait_expired) begin
          state_d = TRAP;
        end
      end
      WB: begin
        state_d      = FETCH;
        retire_cnt_d = retire_cnt_q + 16'd1;
      end
      TRAP:    state_d = TRAP;
      default: state_d = TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      class_q      <= CL_NONE;
      alu_op_q     <= 3'b000;
      retire_cnt_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      class_q      <= class_d;
      alu_op_q     <= alu_op_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // strobes are forced low while rst is held so nothing fires during reset
  always_comb begin
    imem_req     = 1'b0;
    ir_write     = 1'b0;
    pc_inc       = 1'b0;
    reg_write    = 1'b0;
    mem_write    = 1'b0;
    mem_read     = 1'b0;
    load_from_dm = 1'b0;
    ALU_op       = 3'b000;
    branch_taken = 1'b0;
    trap         = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          imem_req = 1'b1;
          ir_write = imem_ready;
          pc_inc   = imem_ready;
        end
        EXEC: begin
          ALU_op       = alu_op_q;
          branch_taken = (class_q == CL_BEQ) && zero;
        end
        MEM: begin
          ALU_op    = alu_op_q;
          mem_read  = (class_q == CL_LW);
          mem_write = (class_q == CL_SW);
        end
        WB: begin
          ALU_op       = alu_op_q;
          reg_write    = 1'b1;
          load_from_dm = (class_q == CL_LW);
        end
        TRAP:    trap = 1'b1;
        default: trap = 1'b0;
      endcase
    end
  end

  assign state      = state_q;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; expected per-cycle output
// vectors are hand-written tables of {state, strobes, ALU_op}.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        zero;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req;
  logic        ir_write;
  logic        pc_inc;
  logic        reg_write;
  logic        mem_write;
  logic        mem_read;
  logic        load_from_dm;
  logic [2:0]  ALU_op;
  logic        branch_taken;
  logic        trap;
  logic [2:0]  state;
  logic [15:0] retire_cnt;

  int n_cmp;
  int n_bad;
  int exp_retire;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zero(zero), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_write(ir_write), .pc_inc(pc_inc),
    .reg_write(reg_write), .mem_write(mem_write), .mem_read(mem_read),
    .load_from_dm(load_from_dm), .ALU_op(ALU_op), .branch_taken(branch_taken),
    .trap(trap), .state(state), .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // strobe field order: imem_req ir_write pc_inc reg_write mem_read mem_write load_from_dm branch_taken trap
  localparam logic [8:0] S_NONE  = 9'b000000000;
  localparam logic [8:0] S_FRDY  = 9'b111000000;
  localparam logic [8:0] S_FWAIT = 9'b100000000;
  localparam logic [8:0] S_RD    = 9'b000010000;
  localparam logic [8:0] S_WR    = 9'b000001000;
  localparam logic [8:0] S_WB    = 9'b000100000;
  localparam logic [8:0] S_WBLD  = 9'b000100100;
  localparam logic [8:0] S_BR    = 9'b000000010;
  localparam logic [8:0] S_TRAP  = 9'b000000001;

  logic [14:0] obs;
  logic [14:0] e;
  assign obs = {state, imem_req, ir_write, pc_inc, reg_write, mem_read, mem_write,
                load_from_dm, branch_taken, trap, ALU_op};

  function automatic logic [14:0] pk(input logic [2:0] st, input logic [8:0] s,
                                     input logic [2:0] alu);
    return {st, s, alu};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
    next_cycle();
    next_cycle();
    n_cmp++;
    if (obs !== 15'd0) begin
      n_bad++; $display("FAIL reset_outputs got %h exp %h", obs, 15'd0);
    end
    n_cmp++;
    if (retire_cnt !== 16'd0) begin
      n_bad++; $display("FAIL reset_retire got %h exp 0000", retire_cnt);
    end
    exp_retire = 0;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({state, imem_req, trap} !== {3'd0, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL reset_release got st=%0d req=%b trap=%b exp st=0 req=1 trap=0",
                        state, imem_req, trap);
    end
  endtask

  task automatic test_alu(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [2:0] alu, input string name);
    imem_ready = 1'b1; dmem_ready = 1'b1; zero = 1'b0;
    for (int c = 0; c < 4; c++) begin
      opcode = (c < 2) ? op : 7'b1111111;
      funct3 = f3; funct7 = f7;
      case (c)
        0:       e = pk(3'd0, S_FRDY, 3'b000);
        1:       e = pk(3'd1, S_NONE, 3'b000);
        2:       e = pk(3'd2, S_NONE, alu);
        default: e = pk(3'd4, S_WB, alu);
      endcase
      #1;
      n_cmp++;
      if (obs !== e) begin
        n_bad++; $display("FAIL %s cycle %0d got %h exp %h", name, c, obs, e);
      end
      next_cycle();
    end
    exp_retire++;
    n_cmp++;
    if ({state, retire_cnt} !== {3'd0, exp_retire[15:0]}) begin
      n_bad++; $display("FAIL %s_done got st=%0d ret=%0d exp st=0 ret=%0d",
                        name, state, retire_cnt, exp_retire);
    end
  endtask

  task automatic test_lw_wait();
    imem_ready = 1'b1; funct3 = 3'b010; funct7 = 7'd0;
    for (int c = 0; c < 8; c++) begin
      opcode = (c < 2) ? 7'b0000011 : 7'b0110011;
      dmem_ready = (c >= 6);
      case (c)
        0:       e = pk(3'd0, S_FRDY, 3'b000);
        1:       e = pk(3'd1, S_NONE, 3'b000);
        2:       e = pk(3'd2, S_NONE, 3'b000);
        7:       e = pk(3'd4, S_WBLD, 3'b000);
        default: e = pk(3'd3, S_RD, 3'b000);
      endcase
      #1;
      n_cmp++;
      if (obs !== e) begin
        n_bad++; $display("FAIL lw_wait cycle %0d got %h exp %h", c, obs, e);
      end
      next_cycle();
    end
    exp_retire++;
    n_cmp++;
    if ({state, retire_cnt} !== {3'd0, exp_retire[15:0]}) begin
      n_bad++; $display("FAIL lw_done got st=%0d ret=%0d exp st=0 ret=%0d",
                        state, retire_cnt, exp_retire);
    end
  endtask

  task automatic test_sw();
    imem_ready = 1'b1; dmem_ready = 1'b1; opcode = 7'b0100011; funct3 = 3'b010; funct7 = 7'd0;
    for (int c = 0; c < 4; c++) begin
      case (c)
        0:       e = pk(3'd0, S_FRDY, 3'b000);
        1:       e = pk(3'd1, S_NONE, 3'b000);
        2:       e = pk(3'd2, S_NONE, 3'b000);
        default: e = pk(3'd3, S_WR, 3'b000);
      endcase
      #1;
      n_cmp++;
      if (obs !== e) begin
        n_bad++; $display("FAIL sw cycle %0d got %h exp %h", c, obs, e);
      end
      next_cycle();
    end
    exp_retire = (exp_retire + 1) % 65536;
    n_cmp++;
    if ({state, retire_cnt} !== {3'd0, exp_retire[15:0]}) begin
      n_bad++; $display("FAIL sw_done got st=%0d ret=%h exp st=0 ret=%h",
                        state, retire_cnt, exp_retire[15:0]);
    end
  endtask

  task automatic test_beq(input logic z);
    imem_ready = 1'b1; dmem_ready = 1'b1; opcode = 7'b1100011; funct3 = 3'b000; funct7 = 7'd0;
    zero = z;
    for (int c = 0; c < 3; c++) begin
      case (c)
        0:       e = pk(3'd0, S_FRDY, 3'b000);
        1:       e = pk(3'd1, S_NONE, 3'b000);
        default: e = pk(3'd2, z ? S_BR : S_NONE, 3'b001);
      endcase
      #1;
      n_cmp++;
      if (obs !== e) begin
        n_bad++; $display("FAIL beq_z%0b cycle %0d got %h exp %h", z, c, obs, e);
      end
      next_cycle();
    end
    exp_retire++;
    n_cmp++;
    if ({state, branch_taken, retire_cnt} !== {3'd0, 1'b0, exp_retire[15:0]}) begin
      n_bad++; $display("FAIL beq_done got st=%0d bt=%b ret=%0d exp st=0 bt=0 ret=%0d",
                        state, branch_taken, retire_cnt, exp_retire);
    end
  endtask

  // jump the counter to its top value instead of retiring 65535 stores
  task automatic test_wrap();
    force dut.retire_cnt_q = 16'hFFFF;
    #1;
    release dut.retire_cnt_q;
    #1;
    exp_retire = 65535;
    n_cmp++;
    if (retire_cnt !== 16'hFFFF) begin
      n_bad++; $display("FAIL wrap_preload got %h exp ffff", retire_cnt);
    end
    test_sw();
  endtask

  task automatic test_reset_mid_mem();
    imem_ready = 1'b1; dmem_ready = 1'b0; opcode = 7'b0000011; funct3 = 3'b010; funct7 = 7'd0;
    for (int c = 0; c < 4; c++) next_cycle();
    n_cmp++;
    if (obs !== pk(3'd3, S_RD, 3'b000)) begin
      n_bad++; $display("FAIL mid_mem_wait got %h exp %h", obs, pk(3'd3, S_RD, 3'b000));
    end
    test_reset();
  endtask

  task automatic test_illegal(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input string name);
    imem_ready = 1'b1; dmem_ready = 1'b1; opcode = op; funct3 = f3; funct7 = f7;
    for (int c = 0; c < 12; c++) begin
      case (c)
        0:       e = pk(3'd0, S_FRDY, 3'b000);
        1:       e = pk(3'd1, S_NONE, 3'b000);
        default: e = pk(3'd5, S_TRAP, 3'b000);
      endcase
      if (c >= 2) opcode = 7'b0110011;
      #1;
      n_cmp++;
      if (obs !== e) begin
        n_bad++; $display("FAIL %s cycle %0d got %h exp %h", name, c, obs, e);
      end
      next_cycle();
    end
    test_reset();
  endtask

  task automatic test_fetch_timeout();
    imem_ready = 1'b0; dmem_ready = 1'b0; opcode = 7'b0110011; funct3 = 3'd0; funct7 = 7'd0;
`ifdef MC_MEM_TIMEOUT_EN
    for (int c = 0; c < 16; c++) begin
      #1;
      n_cmp++;
      if (obs !== pk(3'd0, S_FWAIT, 3'b000)) begin
        n_bad++; $display("FAIL timeout_wait cycle %0d got %h exp %h", c, obs, pk(3'd0, S_FWAIT, 3'b000));
      end
      next_cycle();
    end
    n_cmp++;
    if (obs !== pk(3'd5, S_TRAP, 3'b000)) begin
      n_bad++; $display("FAIL timeout_trap got %h exp %h", obs, pk(3'd5, S_TRAP, 3'b000));
    end
`else
    for (int c = 0; c < 100; c++) begin
      #1;
      n_cmp++;
      if (obs !== pk(3'd0, S_FWAIT, 3'b000)) begin
        n_bad++; $display("FAIL unbounded_wait cycle %0d got %h exp %h", c, obs, pk(3'd0, S_FWAIT, 3'b000));
      end
      next_cycle();
    end
`endif
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; exp_retire = 0;
    rst = 1'b1; opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0; zero = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    test_reset();
    test_alu(7'b0110011, 3'b000, 7'b0000000, 3'b000, "r_add");
    test_alu(7'b0110011, 3'b000, 7'b0100000, 3'b001, "r_sub");
    test_alu(7'b0110011, 3'b111, 7'b0000000, 3'b100, "r_and");
    test_alu(7'b0110011, 3'b101, 7'b0000000, 3'b111, "r_srl");
    test_alu(7'b0010011, 3'b110, 7'b1010101, 3'b010, "i_ori");
    test_alu(7'b0010011, 3'b010, 7'b0000000, 3'b011, "i_slti");
    test_lw_wait();
    test_sw();
    test_beq(1'b1);
    test_beq(1'b0);
    test_wrap();
    test_reset_mid_mem();
    test_illegal(7'b1111111, 3'b000, 7'b0000000, "bad_opcode");
    test_illegal(7'b0110011, 3'b001, 7'b0100000, "bad_r_sub");
    test_illegal(7'b0110011, 3'b000, 7'b0000001, "bad_r_f7");
    test_illegal(7'b0010011, 3'b001, 7'b0000000, "bad_i_f3");
    test_illegal(7'b1100011, 3'b001, 7'b0000000, "bad_bne");
    test_fetch_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
